timer_cap_gen: RTL
==================

Name: timer_cap_gen

Overview:
- Parametrised successor to the 32-bit acquisition timer: free-running CNT_W-bit timestamp counter with wrap pulse.
- Tick generator with a period that is programmable at run time, not fixed by a bit slice.
- CAP_N hardware timestamp-capture channels with valid/ack handshake and sticky overrun flag.
- Sits beside the acquisition front end; capture inputs are strobes already synchronous to clk.

Parameters:
- CNT_W, 32, width of the main counter and of each captured timestamp.
- TICK_W, 24, width of the tick period register and the tick divider.
- TICK_DEF, 1105919, reset value of the tick period (10 ms at 110.592 MHz).
- CAP_N, 2, number of capture channels (1..8).

Ports:
- clk, input, 1, working clock, 110.592 MHz.
- rst, input, 1, one clock; reset is synchronous and active-high.
- clr, input, 1, synchronous clear of the counters, pulses and capture flags.
- ena, input, 1, count enable for the main counter and the tick divider.
- tick_period, input, TICK_W, new tick period, in enabled cycles minus 1.
- tick_load, input, 1, loads tick_period and restarts the divider.
- cap_in, input, CAP_N, per-channel capture strobes.
- cap_ack, input, CAP_N, per-channel consume acknowledge.
- count, output, CNT_W, main counter value.
- pulse_full, output, 1, one-cycle pulse on counter wrap.
- pulse_tick, output, 1, one-cycle tick pulse.
- cap_val, output, CAP_N*CNT_W, captured timestamps; channel i occupies bits [i*CNT_W +: CNT_W].
- cap_valid, output, CAP_N, a timestamp is held and not yet acknowledged.
- cap_ovr, output, CAP_N, sticky overrun flag.

Behaviour:
- Reset values: count=0, pulse_full=0, pulse_tick=0, cap_val=0, cap_valid=0, cap_ovr=0.
- Reset values of internal state: period register=TICK_DEF, divider=0, previous-sample register per channel=1. With the previous sample at 1, a cap_in already high when reset releases does not capture.
- Priority, highest first: rst, clr, tick_load, normal operation.
- Main counter: when ena=1, count is incremented by 1 modulo 2^CNT_W. When ena=0, count holds.
- pulse_full goes to 1 in the cycle after an enabled increment from all-ones to 0, for exactly one cycle.
- Tick divider: when ena=1, the divider increments. When the divider equals the period register and ena=1, the divider goes to 0 and pulse_tick goes to 1 in the next cycle, for one cycle.
- Tick period arithmetic: pulses are spaced period+1 enabled cycles apart. A period of 0 gives pulse_tick on every cycle that follows an enabled cycle.
- tick_load: the period register takes tick_period, the divider goes to 0, and pulse_tick=0 in the next cycle. count is not affected. tick_load has priority over a divider match in the same cycle.
- Decreasing the period without tick_load: if the divider is already above the new period, the divider runs to all-ones, wraps to 0, and no pulse is generated at the wrap. Software must use tick_load when changing the period.
- clr: count, divider, pulse_full, pulse_tick, cap_valid and cap_ovr all go to 0. The period register and cap_val hold their values.
- Capture edge detection: a rising edge on channel i in cycle n means cap_in[i]=1 in cycle n and the previous sample was 0. The previous sample is registered every cycle.
- Capture timing: channel i latches the count value present in cycle n, independent of ena, and cap_valid[i]=1 from cycle n+1.
- Capture handshake: cap_ack[i] in a cycle where cap_valid[i]=1 clears cap_valid[i] and cap_ovr[i] in the next cycle. An ack with cap_valid=0 is ignored.
- Edge while the channel is full: if an edge arrives while cap_valid[i]=1 and there is no ack that cycle, cap_val holds and cap_ovr[i] is set to 1. cap_ovr stays set until the channel is acknowledged or clr is applied.
- Edge and ack in the same cycle: the new timestamp is latched, cap_valid stays 1 and cap_ovr goes to 0.
- Edge and clr in the same cycle: clr wins and nothing is captured.
- Channel independence: all channels are independent and a capture is never blocked by activity on another channel.

Optional Feature:
- Macro: TIMER_CAP_FILT_EN.
- Defined: each cap_in bit passes through a 3-sample majority-free stability filter. The filter output rises only after cap_in has been 1 for 3 consecutive cycles, and falls only after it has been 0 for 3 consecutive cycles. Edge detection acts on the filter output, so the latched count is the value 2 cycles after the raw edge, and pulses shorter than 3 cycles are ignored. The filter output resets to 1.
- Undefined: raw cap_in feeds edge detection directly, with no filter logic.

Test Plan:
- Reset release, then ena=1 for 10 cycles -> count=10, no pulses, all cap_valid=0; cap_in held high through reset produces no capture.
- CNT_W=8, ena=1 from count=0xFE -> count=0xFF, then 0x00; pulse_full=1 in the cycle count reads 0x00 and 0 in the cycles either side.
- tick_load with tick_period=4, then ena=1 -> pulse_tick every 5 cycles; ena toggled 1/0 -> period 10 cycles; tick_load mid-count -> divider restarts and no pulse in the next cycle.
- cap_in[0] rises when count=0x1234 -> cap_val[0]=0x1234 and cap_valid[0]=1 one cycle later; a second edge without ack -> cap_ovr[0]=1 and value held; cap_ack -> both clear.
- Edge and ack on channel 1 in the same cycle with count=77 -> cap_val[1]=77, cap_valid[1]=1, cap_ovr[1]=0; clr with edge on channel 0 -> no capture, count=0.
- With TIMER_CAP_FILT_EN: 2-cycle cap_in pulse -> no capture; 4-cycle pulse starting at count=100 -> cap_val=102.

Source files
------------

// File: rtl/timer_cap_gen.sv
// -----------------------------------------------------------------------------
// timer_cap_gen
// Free-running timestamp counter with a wrap pulse, a run-time programmable
// tick generator, and CAP_N timestamp-capture channels with a valid/ack
// handshake and a sticky overrun flag.
//
// Optional build macro: TIMER_CAP_FILT_EN
//   When defined, each cap_in bit passes through a 3-sample stability filter
//   before edge detection. The latched count is then the value 2 cycles after
//   the raw edge, and pulses shorter than 3 cycles are ignored.
//   When undefined, raw cap_in feeds edge detection directly.
//
// Ports:
//   clk          working clock
//   rst          synchronous active-high reset
//   clr          synchronous clear of counters, pulses and capture flags
//   ena          count enable for the main counter and the tick divider
//   tick_period  new tick period (enabled cycles minus 1)
//   tick_load    loads tick_period and restarts the divider
//   cap_in       per-channel capture strobes (synchronous to clk)
//   cap_ack      per-channel consume acknowledge
//   count        main counter value
//   pulse_full   one-cycle pulse after the counter wraps
//   pulse_tick   one-cycle tick pulse
//   cap_val      captured timestamps, channel i at [i*CNT_W +: CNT_W]
//   cap_valid    a timestamp is held and not yet acknowledged
//   cap_ovr      sticky overrun flag
// -----------------------------------------------------------------------------
module timer_cap_gen #(
  parameter int CNT_W    = 32,
  parameter int TICK_W   = 24,
  parameter int TICK_DEF = 1105919,
  parameter int CAP_N    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   ena,
  input  logic [TICK_W-1:0]      tick_period,
  input  logic                   tick_load,
  input  logic [CAP_N-1:0]       cap_in,
  input  logic [CAP_N-1:0]       cap_ack,
  output logic [CNT_W-1:0]       count,
  output logic                   pulse_full,
  output logic                   pulse_tick,
  output logic [CAP_N*CNT_W-1:0] cap_val,
  output logic [CAP_N-1:0]       cap_valid,
  output logic [CAP_N-1:0]       cap_ovr
);

  localparam logic [TICK_W-1:0] TICK_RST = TICK_W'(TICK_DEF);

  logic [TICK_W-1:0] period_reg;
  logic [TICK_W-1:0] div_reg;

  // ---------------------------------------------------------------------------
  // Main counter and wrap pulse. tick_load never touches the counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count      <= '0;
      pulse_full <= 1'b0;
    end else begin
      pulse_full <= ena && (count == {CNT_W{1'b1}});
      if (ena) begin
        count <= count + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tick divider. A divider already above a shrunken period simply counts up
  // to all-ones and wraps silently; only an exact match produces a pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      period_reg <= TICK_RST;
      div_reg    <= '0;
      pulse_tick <= 1'b0;
    end else if (clr) begin
      div_reg    <= '0;
      pulse_tick <= 1'b0;
    end else if (tick_load) begin
      period_reg <= tick_period;
      div_reg    <= '0;
      pulse_tick <= 1'b0;
    end else if (ena) begin
      if (div_reg == period_reg) begin
        div_reg    <= '0;
        pulse_tick <= 1'b1;
      end else begin
        div_reg    <= div_reg + 1'b1;
        pulse_tick <= 1'b0;
      end
    end else begin
      pulse_tick <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture channels
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CAP_N; gi++) begin : g_cap
      logic             samp;      // (optionally filtered) strobe level
      logic             prev_reg;  // previous sample, resets high
      logic             rise;
      logic             ack_eff;
      logic [CNT_W-1:0] val_reg;
      logic             valid_reg;
      logic             ovr_reg;

`ifdef TIMER_CAP_FILT_EN
      // hist_reg[0] is cap_in one cycle ago, hist_reg[1] two cycles ago.
      // The filter level is held in prev_reg, so it doubles as the
      // edge-detector history.
      logic [1:0] hist_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          hist_reg <= 2'b11;
        end else begin
          hist_reg <= {hist_reg[0], cap_in[gi]};
        end
      end

      always_comb begin
        samp = prev_reg;
        if (cap_in[gi] && (hist_reg == 2'b11)) begin
          samp = 1'b1;
        end else if (!cap_in[gi] && (hist_reg == 2'b00)) begin
          samp = 1'b0;
        end
      end
`else
      assign samp = cap_in[gi];
`endif

      assign rise    = samp && !prev_reg;
      assign ack_eff = cap_ack[gi] && valid_reg;

      // History register runs every cycle, including during clr, so a strobe
      // that was high across a clear does not fire afterwards.
      always_ff @(posedge clk) begin
        if (rst) begin
          prev_reg <= 1'b1;
        end else begin
          prev_reg <= samp;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          val_reg   <= '0;
          valid_reg <= 1'b0;
          ovr_reg   <= 1'b0;
        end else if (clr) begin
          valid_reg <= 1'b0;
          ovr_reg   <= 1'b0;
        end else if (rise) begin
          if (!valid_reg || ack_eff) begin
            // Empty slot, or the old value is consumed this same cycle.
            val_reg   <= count;
            valid_reg <= 1'b1;
            ovr_reg   <= 1'b0;
          end else begin
            ovr_reg   <= 1'b1;
          end
        end else if (ack_eff) begin
          valid_reg <= 1'b0;
          ovr_reg   <= 1'b0;
        end
      end

      assign cap_val[gi*CNT_W +: CNT_W] = val_reg;
      assign cap_valid[gi]              = valid_reg;
      assign cap_ovr[gi]                = ovr_reg;
    end
  endgenerate

endmodule
